// File: rtl/vga_framebuffer.sv
// Frame buffer for the 1368x768 VGA driver: 171x96 3-bit image, 8x8 blocks.
// Lookahead read pipeline, single-pixel write port and a full-buffer clear engine.
module vga_framebuffer #(
  parameter int SCREEN_X    = 1368,
  parameter int SCREEN_Y    = 768,
  parameter int H_TOTAL     = 1801,
  parameter int V_TOTAL     = 796,
  parameter int SCALE_SHIFT = 3,
  parameter int FB_W        = SCREEN_X >> SCALE_SHIFT,
  parameter int FB_H        = SCREEN_Y >> SCALE_SHIFT,
  parameter int LOOKAHEAD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  output logic [2:0]  pixel_out,
  input  logic        wr_en,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [2:0]  wr_data,
  output logic        wr_ready,
  output logic        wr_err,
  input  logic        clr_start,
  input  logic [2:0]  clr_color,
  output logic        busy,
  output logic        clr_done
);

  localparam int DEPTH = FB_W * FB_H;
  localparam logic [14:0] LAST = 15'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t      state, stateNext;
  logic [14:0] cnt, cntNext;
  logic [2:0]  clrColor, clrColorNext;
  logic        doneNext;
  logic        errNext;

  logic        ramWe;
  logic [14:0] ramWa;
  logic [2:0]  ramWd;
  logic [2:0]  mem [DEPTH];
  logic [2:0]  ramQ;

  // Stage 0: coordinates LOOKAHEAD pixels ahead, wrapped like the driver
  logic [11:0] xSum, xl, yl;
  logic        visNext;
  logic [14:0] addrNext;

  always_comb begin
    xSum = {1'b0, pos_x} + 12'(LOOKAHEAD);
    xl   = xSum;
    yl   = {1'b0, pos_y};
    if (xSum >= 12'(H_TOTAL)) begin
      xl = xSum - 12'(H_TOTAL);
      yl = {1'b0, pos_y} + 12'd1;
    end
    if (yl >= 12'(V_TOTAL)) yl = '0;
    visNext  = (xl < 12'(SCREEN_X)) && (yl < 12'(SCREEN_Y));
    addrNext = '0;
    if (visNext)
      addrNext = 15'(yl >> SCALE_SHIFT) * 15'(FB_W)
               + 15'(xl >> SCALE_SHIFT);
  end

  // Stage 1/2: address register, then RAM data with aligned visibility
  logic        vis, visD;
  logic [14:0] rdAddr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vis    <= 1'b0;
      visD   <= 1'b0;
      rdAddr <= '0;
    end else begin
      vis    <= visNext;
      visD   <= vis;
      rdAddr <= addrNext;
    end
  end

  assign pixel_out = visD ? ramQ : 3'b000;

  // Nonblocking write and read in one process gives old-data on collision
  always_ff @(posedge clk) begin
    if (ramWe) mem[ramWa] <= ramWd;
    ramQ <= mem[rdAddr];
  end

  logic        inRange;
  logic        wrAccept;
  logic [14:0] wrAddr;

  assign wr_ready = (state == IDLE);
  assign busy     = (state == CLEAR);
  assign inRange  = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  assign wrAccept = wr_en && wr_ready && inRange;
  assign wrAddr   = 15'(wr_y) * 15'(FB_W) + 15'(wr_x);
  assign errNext  = wr_en && !(wr_ready && inRange);

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    clrColorNext = clrColor;
    doneNext     = 1'b0;
    ramWe        = 1'b0;
    ramWa        = wrAddr;
    ramWd        = wr_data;
    unique case (state)
      IDLE: begin
        ramWe = wrAccept;
        if (clr_start) begin
          stateNext    = CLEAR;
          cntNext      = '0;
          clrColorNext = clr_color;
        end
      end
      CLEAR: begin
        ramWe   = 1'b1;
        ramWa   = cnt;
        ramWd   = clrColor;
        cntNext = cnt + 15'd1;
        if (cnt == LAST) begin
          stateNext = IDLE;
          cntNext   = '0;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // A reset edge aborts the clear without one more write
    if (rst) ramWe = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clrColor <= '0;
      clr_done <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      clrColor <= clrColorNext;
      clr_done <= doneNext;
      wr_err   <= errNext;
    end
  end

endmodule
